// File: rtl/m_fifo_drain.sv
// Pop-side consumer for m_fifo: pops words when allowed and serializes each
// WIDTH-bit word into RATIO narrower valid/ready beats, LSB slice first.
module m_fifo_drain #(
  parameter int WIDTH = 4,
  parameter int RATIO = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     fifo_empty,
  input  logic [WIDTH-1:0]         fifo_pop_data,
  output logic                     fifo_pop,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH/RATIO-1:0]   out_data,
  output logic                     out_last,
  output logic                     busy
);

  localparam int OUT_W = WIDTH / RATIO;
  localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACTIVE = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   word_q, word_d;
  logic [CNT_W-1:0]   beat_q, beat_d;

  logic last_beat;
  logic acc;
  logic load;

  assign out_valid = (state_q == S_ACTIVE);
  assign busy      = out_valid;
  assign last_beat = (beat_q == CNT_W'(RATIO - 1));
  assign out_last  = out_valid & last_beat;
  assign acc       = out_valid & out_ready;

  // A new word may enter when idle, or in the same cycle the last beat of the
  // current word is taken, which gives back-to-back words with no bubble.
  assign load     = ~rst & enable & ~fifo_empty & (~out_valid | (acc & last_beat));
  assign fifo_pop = load;

  // Beat selection as an explicit compare-and-pick so non-power-of-two
  // RATIO values never index past the last slice.
  always_comb begin
    out_data = '0;
    for (int i = 0; i < RATIO; i++) begin
      if (beat_q == CNT_W'(i)) begin
        out_data = word_q[i*OUT_W +: OUT_W];
      end
    end
  end

  always_comb begin
    // NOTE: every next-state signal is defaulted to its current value before
    // any branch, so no path leaves it unassigned and no latch is inferred.
    state_d = state_q;
    word_d  = word_q;
    beat_d  = beat_q;

    if (load) begin
      word_d  = fifo_pop_data;
      beat_d  = '0;
      state_d = S_ACTIVE;
    end else if (acc) begin
      if (last_beat) begin
        state_d = S_IDLE;
        beat_d  = '0;
      end else begin
        beat_d = beat_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of process evaluation order.
    if (rst) begin
      state_q <= S_IDLE;
      word_q  <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      beat_q  <= beat_d;
    end
  end

endmodule

// File: tb/tb_m_fifo_drain.sv
// Self-checking bench for m_fifo_drain: cycle tables, hand-written corner
// sequences and a randomized run scored against a beat-stream model.
module tb_m_fifo_drain;

  logic       clk;
  logic       rst;

  // WIDTH=8, RATIO=2 instance
  logic       enable0, fifo_empty0, fifo_pop0, out_valid0, out_ready0, out_last0, busy0;
  logic [7:0] pop_data0;
  logic [3:0] out_data0;

  // WIDTH=4, RATIO=1 instance
  logic       enable1, fifo_empty1, fifo_pop1, out_valid1, out_ready1, out_last1, busy1;
  logic [3:0] pop_data1;
  logic [3:0] out_data1;

  m_fifo_drain #(.WIDTH(8), .RATIO(2)) dut (
    .clk(clk), .rst(rst), .enable(enable0), .fifo_empty(fifo_empty0),
    .fifo_pop_data(pop_data0), .fifo_pop(fifo_pop0), .out_valid(out_valid0),
    .out_ready(out_ready0), .out_data(out_data0), .out_last(out_last0), .busy(busy0)
  );

  m_fifo_drain #(.WIDTH(4), .RATIO(1)) dut1 (
    .clk(clk), .rst(rst), .enable(enable1), .fifo_empty(fifo_empty1),
    .fifo_pop_data(pop_data1), .fifo_pop(fifo_pop1), .out_valid(out_valid1),
    .out_ready(out_ready1), .out_data(out_data1), .out_last(out_last1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assert property (@(posedge clk) !(fifo_pop0 && fifo_empty0))
    else $error("POP ON EMPTY on dut");
  assert property (@(posedge clk) !(fifo_pop1 && fifo_empty1))
    else $error("POP ON EMPTY on dut1");

  int checks = 0;
  int errors = 0;

  logic [7:0] q0[$];
  logic [3:0] q1[$];

  typedef struct {
    logic [3:0] d;
    logic       l;
  } beat_t;
  beat_t eb[$];

  typedef struct {
    bit         en;
    bit         rdy;
    bit         push;
    logic [7:0] pd;
    bit         pop;
    bit         v;
    logic [3:0] d;
    bit         l;
  } vec_t;
  vec_t vecs[$];

  bit         sb_on = 0;
  bit         stall_prev = 0;
  logic [3:0] prev_data;
  logic       prev_last;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fifo_update();
    fifo_empty0 = (q0.size() == 0);
    pop_data0   = fifo_empty0 ? 8'h00 : q0[0];
    fifo_empty1 = (q1.size() == 0);
    pop_data1   = fifo_empty1 ? 4'h0 : q1[0];
  endtask

  task automatic push0(input logic [7:0] d);
    q0.push_back(d);
    fifo_update();
  endtask

  task automatic push1(input logic [3:0] d);
    q1.push_back(d);
    fifo_update();
  endtask

  // One clock: score the current cycle, take the edge, then apply FIFO pops.
  task automatic tick();
    bit         p0 = fifo_pop0;
    bit         p1 = fifo_pop1;
    logic [7:0] w0 = pop_data0;
    beat_t      b;
    if (sb_on) begin
      if (stall_prev) begin
        check("stall_valid", out_valid0, 1'b1);
        check("stall_data", out_data0, prev_data);
        check("stall_last", out_last0, prev_last);
      end
      if (out_valid0 && out_ready0) begin
        if (eb.size() == 0) begin
          check("sb_unexpected_beat", 1'b1, 1'b0);
        end else begin
          b = eb.pop_front();
          check("sb_data", out_data0, b.d);
          check("sb_last", out_last0, b.l);
        end
      end
      if (p0) check("sb_pop_nonempty", fifo_empty0, 1'b0);
      stall_prev = out_valid0 && !out_ready0;
      prev_data  = out_data0;
      prev_last  = out_last0;
    end
    @(posedge clk);
    #1;
    if (p0 && q0.size() > 0) begin
      void'(q0.pop_front());
      if (sb_on) begin
        for (int i = 0; i < 2; i++) begin
          b.d = 4'((w0 >> (4 * i)) & 8'h0F);
          b.l = (i == 1);
          eb.push_back(b);
        end
      end
    end
    if (p1 && q1.size() > 0) void'(q1.pop_front());
    fifo_update();
  endtask

  task automatic add(input bit en, input bit rdy, input bit push, input logic [7:0] pd,
                     input bit pop, input bit v, input logic [3:0] d, input bit l);
    vec_t r;
    r = '{en: en, rdy: rdy, push: push, pd: pd, pop: pop, v: v, d: d, l: l};
    vecs.push_back(r);
  endtask

  initial begin
    rst = 1'b1;
    enable0 = 1'b1; out_ready0 = 1'b0;
    enable1 = 1'b1; out_ready1 = 1'b1;
    fifo_update();

    // Reset state
    repeat (3) tick();
    #2;
    check("rst_valid", out_valid0, 1'b0);
    check("rst_last", out_last0, 1'b0);
    check("rst_busy", busy0, 1'b0);
    check("rst_pop", fifo_pop0, 1'b0);
    check("rst_data", out_data0, 4'h0);
    rst = 1'b0;

    // Cycle table:      en rdy push pd     pop v  d     l
    // single word 0xA5
    add(1, 1, 1, 8'hA5, 1, 0, 4'h0, 0);
    add(1, 1, 0, 8'h00, 0, 1, 4'h5, 0);
    add(1, 1, 0, 8'h00, 0, 1, 4'hA, 1);
    add(1, 1, 0, 8'h00, 0, 0, 4'h0, 0);
    // streaming 0x12, 0x34, 0x56
    add(1, 1, 1, 8'h12, 1, 0, 4'h0, 0);
    add(1, 1, 1, 8'h34, 0, 1, 4'h2, 0);
    add(1, 1, 1, 8'h56, 1, 1, 4'h1, 1);
    add(1, 1, 0, 8'h00, 0, 1, 4'h4, 0);
    add(1, 1, 0, 8'h00, 1, 1, 4'h3, 1);
    add(1, 1, 0, 8'h00, 0, 1, 4'h6, 0);
    add(1, 1, 0, 8'h00, 0, 1, 4'h5, 1);
    add(1, 1, 0, 8'h00, 0, 0, 4'h0, 0);
    // backpressure on 0xC3 with 0x77 waiting behind it
    add(1, 0, 1, 8'hC3, 1, 0, 4'h0, 0);
    add(1, 0, 1, 8'h77, 0, 1, 4'h3, 0);
    for (int i = 0; i < 4; i++) add(1, 0, 0, 8'h00, 0, 1, 4'h3, 0);
    add(1, 1, 0, 8'h00, 0, 1, 4'h3, 0);
    add(1, 1, 0, 8'h00, 1, 1, 4'hC, 1);
    add(1, 1, 0, 8'h00, 0, 1, 4'h7, 0);
    add(1, 1, 0, 8'h00, 0, 1, 4'h7, 1);
    add(1, 1, 0, 8'h00, 0, 0, 4'h0, 0);
    // enable dropped during beat 0 of 0x21 while 0x43 waits
    add(1, 1, 1, 8'h21, 1, 0, 4'h0, 0);
    add(0, 1, 1, 8'h43, 0, 1, 4'h1, 0);
    add(0, 1, 0, 8'h00, 0, 1, 4'h2, 1);
    add(0, 1, 0, 8'h00, 0, 0, 4'h0, 0);
    add(0, 1, 0, 8'h00, 0, 0, 4'h0, 0);
    add(1, 1, 0, 8'h00, 1, 0, 4'h0, 0);
    add(1, 1, 0, 8'h00, 0, 1, 4'h3, 0);
    add(1, 1, 0, 8'h00, 0, 1, 4'h4, 1);
    add(1, 1, 0, 8'h00, 0, 0, 4'h0, 0);
    // empty FIFO with ready high
    add(1, 1, 0, 8'h00, 0, 0, 4'h0, 0);
    add(1, 1, 0, 8'h00, 0, 0, 4'h0, 0);

    foreach (vecs[k]) begin
      tick();
      if (vecs[k].push) push0(vecs[k].pd);
      enable0    = vecs[k].en;
      out_ready0 = vecs[k].rdy;
      #2;
      check($sformatf("vec%0d_pop", k), fifo_pop0, vecs[k].pop);
      check($sformatf("vec%0d_valid", k), out_valid0, vecs[k].v);
      check($sformatf("vec%0d_busy", k), busy0, vecs[k].v);
      check($sformatf("vec%0d_last", k), out_last0, vecs[k].l);
      if (vecs[k].v) check($sformatf("vec%0d_data", k), out_data0, vecs[k].d);
    end

    // Reset during beat 0 of 0x9F while another word is queued
    tick();
    push0(8'h9F);
    enable0 = 1'b1; out_ready0 = 1'b0;
    #2;
    check("rstmid_pop", fifo_pop0, 1'b1);
    tick();
    #2;
    check("rstmid_valid0", out_valid0, 1'b1);
    check("rstmid_beat0", out_data0, 4'hF);
    push0(8'h11);
    out_ready0 = 1'b1;
    rst = 1'b1;
    #2;
    check("rstmid_nopop_in_rst", fifo_pop0, 1'b0);
    tick();
    #2;
    check("rstmid_valid_after", out_valid0, 1'b0);
    check("rstmid_last_after", out_last0, 1'b0);
    check("rstmid_busy_after", busy0, 1'b0);
    check("rstmid_pop_gated", fifo_pop0, 1'b0);
    check("rstmid_data_cleared", out_data0, 4'h0);
    q0.delete();
    q1.delete();
    fifo_update();
    rst = 1'b0;
    tick();

    // RATIO=1 pass-through: 0x7 then 0x8
    push1(4'h7);
    #2;
    check("r1_pop_a", fifo_pop1, 1'b1);
    tick();
    push1(4'h8);
    #2;
    check("r1_valid_a", out_valid1, 1'b1);
    check("r1_data_a", out_data1, 4'h7);
    check("r1_last_a", out_last1, 1'b1);
    check("r1_pop_b", fifo_pop1, 1'b1);
    tick();
    #2;
    check("r1_valid_b", out_valid1, 1'b1);
    check("r1_data_b", out_data1, 4'h8);
    check("r1_last_b", out_last1, 1'b1);
    tick();
    #2;
    check("r1_idle", out_valid1, 1'b0);
    check("r1_last_idle", out_last1, 1'b0);

    // Randomized traffic scored against the beat-stream model
    eb.delete();
    stall_prev = 0;
    sb_on = 1;
    for (int c = 0; c < 800; c++) begin
      tick();
      if (q0.size() < 6 && $urandom_range(0, 9) < 4) push0(8'($urandom));
      enable0    = ($urandom_range(0, 9) != 0);
      out_ready0 = ($urandom_range(0, 3) != 0);
      #2;
    end

    // Drain with bounded wait
    begin
      bit done = 0;
      for (int c = 0; c < 200 && !done; c++) begin
        tick();
        enable0 = 1'b1; out_ready0 = 1'b1;
        #2;
        done = (q0.size() == 0) && !out_valid0 && (eb.size() == 0);
      end
      check("drain_done", done, 1'b1);
      check("drain_model_empty", eb.size(), 0);
    end
    sb_on = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
